// File: rtl/xconnect_feeder_if.sv
// xconnect_feeder_if: host-side valid/ready streams into and out of the feeder
interface xconnect_feeder_if #(
    parameter int WORD_SIZE        = 256,
    parameter int GROUP_SIZE_WIDTH = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WORD_SIZE-1:0]        in_data;
    logic [GROUP_SIZE_WIDTH-1:0] in_group_size;
    logic                        out_valid;
    logic                        out_ready;
    logic [WORD_SIZE-1:0]        out_data;
    logic                        out_last;
    modport master (
        output in_valid, in_data, in_group_size, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_group_size, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/xconnect_feeder.sv
// xconnect_feeder: gathers a frame of PE words for xconnect, waits out its latency, streams results back
module xconnect_feeder #(
    parameter int WORD_SIZE        = 256,
    parameter int NOF_PES          = 16,
    parameter int NOF_LEVELS       = $clog2(NOF_PES),
    parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int XC_LATENCY       = NOF_LEVELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    xconnect_feeder_if.slave                     s,
    output logic [WORD_SIZE*NOF_PES-1:0]         input_pes_data,
    output logic [GROUP_SIZE_WIDTH*NOF_PES-1:0]  groups_sizes,
    input  logic [WORD_SIZE*NOF_PES-1:0]         output_pes_data,
    output logic                                 busy,
    output logic                                 cfg_error
);
    localparam int W  = WORD_SIZE;
    localparam int G  = GROUP_SIZE_WIDTH;
    localparam int CW = $clog2(XC_LATENCY + 1);
    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
    state_t                state_q, state_d;
    logic [NOF_LEVELS-1:0] idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W*NOF_PES-1:0]  pes_q, pes_d, res_q, res_d;
    logic [G*NOF_PES-1:0]  gs_q, gs_d;
    logic [W-1:0]          odata_q, odata_d;
    logic                  in_ready_q, out_valid_q, out_last_q, err_q, err_d, busy_q;
    logic                  in_hs, out_hs, last_idx, gs_ok;

    assign in_hs    = s.in_valid && in_ready_q;
    assign out_hs   = out_valid_q && s.out_ready;
    assign last_idx = idx_q == NOF_LEVELS'(NOF_PES - 1);
    // legal group size: nonzero power of two no larger than the PE count
    assign gs_ok    = s.in_group_size != '0
                   && (s.in_group_size & (s.in_group_size - G'(1))) == '0
                   && s.in_group_size <= G'(NOF_PES);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pes_d   = pes_q;
        gs_d    = gs_q;
        res_d   = res_q;
        odata_d = odata_q;
        err_d   = err_q;
        if (state_q == LOAD && in_hs) begin
            pes_d[idx_q*W +: W] = s.in_data;
            gs_d[idx_q*G +: G]  = gs_ok ? s.in_group_size : G'(1);
            err_d   = err_q || !gs_ok;
            idx_d   = last_idx ? '0 : idx_q + NOF_LEVELS'(1);
            cnt_d   = '0;
            state_d = last_idx ? RUN : LOAD;
        end
        if (state_q == RUN) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XC_LATENCY - 1)) begin
                cnt_d   = cnt_q;
                res_d   = output_pes_data;
                odata_d = output_pes_data[W-1:0];
                state_d = DRAIN;
            end
        end
        if (state_q == DRAIN && out_hs) begin
            idx_d   = last_idx ? '0 : idx_q + NOF_LEVELS'(1);
            odata_d = res_q[idx_d*W +: W];
            state_d = last_idx ? LOAD : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            pes_q       <= '0;
            gs_q        <= '0;
            res_q       <= '0;
            odata_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pes_q       <= pes_d;
            gs_q        <= gs_d;
            res_q       <= res_d;
            odata_q     <= odata_d;
            err_q       <= err_d;
            in_ready_q  <= state_d == LOAD;
            out_valid_q <= state_d == DRAIN;
            out_last_q  <= state_d == DRAIN && idx_d == NOF_LEVELS'(NOF_PES - 1);
            busy_q      <= state_d != LOAD || idx_d != '0;
        end
    end

    assign s.in_ready      = in_ready_q;
    assign s.out_valid     = out_valid_q;
    assign s.out_data      = odata_q;
    assign s.out_last      = out_last_q;
    assign input_pes_data  = pes_q;
    assign groups_sizes    = gs_q;
    assign busy            = busy_q;
    assign cfg_error       = err_q;
endmodule
